// File: rtl/cosim_commit_sequencer.sv
// Per-hart commit FIFOs serialised round-robin onto one registered
// valid/ready channel feeding the co-simulation step/commit checker.
module cosim_commit_sequencer #(
    parameter int NUM_HARTS  = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int PAYLOAD_W  = 168,
    parameter int HART_W     = $clog2(NUM_HARTS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_HARTS-1:0]           commit_valid_i,
    output logic [NUM_HARTS-1:0]           commit_ready_o,
    input  logic [NUM_HARTS*PAYLOAD_W-1:0] commit_info_i,
    output logic                           chk_valid_o,
    input  logic                           chk_ready_i,
    output logic [HART_W-1:0]              chk_hart_o,
    output logic [PAYLOAD_W-1:0]           chk_info_o,
    output logic [31:0]                    chk_seq_o,
    input  logic                           halt_i,
    input  logic                           resume_i,
    output logic                           halted_o,
    output logic [31:0]                    total_cnt_o
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int SCAN_W = HART_W + 1;

    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [SCAN_W-1:0] NH        = SCAN_W'(NUM_HARTS);
    localparam logic [HART_W-1:0] LAST_HART = HART_W'(NUM_HARTS - 1);

    typedef enum logic {
        ST_RUN,
        ST_HALT
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [PAYLOAD_W-1:0] r_mem  [NUM_HARTS][FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wptr [NUM_HARTS];
    logic [PTR_W-1:0]     r_rptr [NUM_HARTS];
    logic [CNT_W-1:0]     r_cnt  [NUM_HARTS];
    logic [31:0]          r_seq  [NUM_HARTS];

    logic [HART_W-1:0]    r_rr_ptr;
    logic                 r_valid;
    logic [HART_W-1:0]    r_hart;
    logic [PAYLOAD_W-1:0] r_info;
    logic [31:0]          r_seq_out;
    logic [31:0]          r_total;

    logic [NUM_HARTS-1:0] w_full;
    logic [NUM_HARTS-1:0] w_nonempty;
    logic [NUM_HARTS-1:0] w_push;
    logic [NUM_HARTS-1:0] w_pop;
    logic                 w_run;
    logic                 w_free;
    logic                 w_accept;
    logic                 w_found;
    logic                 w_grant;
    logic [HART_W-1:0]    w_gnt_idx;
    logic [SCAN_W-1:0]    w_scan;
    logic [PAYLOAD_W-1:0] w_head;

    // Ready depends on occupancy only, so a full FIFO refuses even while popping.
    always_comb begin
        w_full     = '0;
        w_nonempty = '0;
        w_push     = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            w_full[h]     = (r_cnt[h] == FULL_CNT);
            w_nonempty[h] = (r_cnt[h] != '0);
            w_push[h]     = commit_valid_i[h] && !w_full[h];
        end
    end

    assign commit_ready_o = ~w_full;

    assign w_free   = !r_valid || chk_ready_i;
    assign w_accept = r_valid && chk_ready_i;

    // First non-empty hart at or after the pointer, wrapping.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_scan    = '0;
        for (int i = 0; i < NUM_HARTS; i++) begin
            w_scan = {1'b0, r_rr_ptr} + SCAN_W'(i);
            if (w_scan >= NH) begin
                w_scan = w_scan - NH;
            end
            if (!w_found && w_nonempty[w_scan[HART_W-1:0]]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_scan[HART_W-1:0];
            end
        end
    end

    assign w_grant = w_run && w_free && w_found;
    assign w_head  = r_mem[w_gnt_idx][r_rptr[w_gnt_idx]];

    always_comb begin
        w_pop = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            w_pop[h] = w_grant && (w_gnt_idx == HART_W'(h));
        end
    end

    always_ff @(posedge clk) begin
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (w_push[h]) begin
                r_mem[h][r_wptr[h]] <= commit_info_i[h*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                r_wptr[h] <= '0;
                r_rptr[h] <= '0;
                r_cnt[h]  <= '0;
                r_seq[h]  <= '0;
            end
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (w_push[h]) begin
                    r_wptr[h] <= r_wptr[h] + PTR_W'(1);
                end
                if (w_pop[h]) begin
                    r_rptr[h] <= r_rptr[h] + PTR_W'(1);
                    r_seq[h]  <= r_seq[h] + 32'd1;
                end
                r_cnt[h] <= r_cnt[h] + CNT_W'(w_push[h]) - CNT_W'(w_pop[h]);
            end
        end
    end

    // Output register: loads on grant, drains to invalid when free and idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_hart    <= '0;
            r_info    <= '0;
            r_seq_out <= '0;
            r_total   <= '0;
            r_rr_ptr  <= '0;
        end else begin
            if (w_accept) begin
                r_total <= r_total + 32'd1;
            end
            if (w_grant) begin
                r_valid   <= 1'b1;
                r_hart    <= w_gnt_idx;
                r_info    <= w_head;
                r_seq_out <= r_seq[w_gnt_idx];
                r_rr_ptr  <= (w_gnt_idx == LAST_HART) ? '0 : w_gnt_idx + HART_W'(1);
            end else if (w_free) begin
                r_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Halt has priority over resume when both arrive together.
    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                w_run = 1'b1;
                if (halt_i) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                if (resume_i && !halt_i) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign chk_valid_o = r_valid;
    assign chk_hart_o  = r_hart;
    assign chk_info_o  = r_info;
    assign chk_seq_o   = r_seq_out;
    assign halted_o    = (r_state == ST_HALT);
    assign total_cnt_o = r_total;

endmodule

// File: tb/tb_cosim_commit_sequencer.sv
// Bench for cosim_commit_sequencer: vector table, directed corner
// sequences, then random traffic against a queue-based reference.
module tb_cosim_commit_sequencer;

    localparam int NH  = 4;
    localparam int DEP = 8;
    localparam int PW  = 168;
    localparam int HW  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NH-1:0]     commit_valid_i = '0;
    logic [NH-1:0]     commit_ready_o;
    logic [NH*PW-1:0]  commit_info_i = '0;
    logic              chk_valid_o;
    logic              chk_ready_i = 1'b0;
    logic [HW-1:0]     chk_hart_o;
    logic [PW-1:0]     chk_info_o;
    logic [31:0]       chk_seq_o;
    logic              halt_i = 1'b0;
    logic              resume_i = 1'b0;
    logic              halted_o;
    logic [31:0]       total_cnt_o;

    always #5 clk = ~clk;

    cosim_commit_sequencer #(
        .NUM_HARTS (NH),
        .FIFO_DEPTH(DEP),
        .PAYLOAD_W (PW),
        .HART_W    (HW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .commit_valid_i(commit_valid_i),
        .commit_ready_o(commit_ready_o),
        .commit_info_i (commit_info_i),
        .chk_valid_o   (chk_valid_o),
        .chk_ready_i   (chk_ready_i),
        .chk_hart_o    (chk_hart_o),
        .chk_info_o    (chk_info_o),
        .chk_seq_o     (chk_seq_o),
        .halt_i        (halt_i),
        .resume_i      (resume_i),
        .halted_o      (halted_o),
        .total_cnt_o   (total_cnt_o)
    );

    int            n_checks = 0;
    int            n_fail = 0;
    int            pushcnt [NH];
    logic [PW-1:0] drv_rec [NH];

    // Reference model state
    logic [PW-1:0] mq [NH][$];
    logic          m_valid;
    int            m_hart;
    logic [PW-1:0] m_info;
    logic [31:0]   m_seq;
    logic [31:0]   m_seqc [NH];
    int            m_ptr;
    logic          m_halted;
    logic [31:0]   m_total;

    typedef struct {
        bit            rst;
        logic [NH-1:0] v;
        logic          r;
        logic          e_val;
        int            e_hart;
        int            e_seq;
        int            e_tot;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [PW-1:0] make_rec(input int h, input int n);
        logic [63:0] pc;
        logic [63:0] data;
        logic [31:0] ins;
        logic [4:0]  dst;
        pc   = 64'h8000_0000 + 64'(n) * 64'd4;
        ins  = 32'h0000_0013 + 32'(n << 7);
        data = {32'(h), 32'(n)} ^ 64'h5a5a_0000_0000_a5a5;
        dst  = 5'(h * 8 + n);
        return {1'b0, (n % 3 == 0), n[0], dst, data, ins, pc};
    endfunction

    function automatic vec_t mk(input bit rst, input logic [NH-1:0] v,
                                input logic r, input logic ev,
                                input int eh, input int es, input int et);
        vec_t x;
        x.rst = rst; x.v = v; x.r = r;
        x.e_val = ev; x.e_hart = eh; x.e_seq = es; x.e_tot = et;
        return x;
    endfunction

    task automatic check(input string nm, input logic [PW-1:0] act,
                         input logic [PW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic ev,
                              input int eh, input int es, input int et);
        check({tag, "_valid"}, PW'(chk_valid_o), PW'(ev));
        if (ev) begin
            check({tag, "_hart"}, PW'(chk_hart_o), PW'(eh));
            check({tag, "_seq"}, PW'(chk_seq_o), PW'(es));
            check({tag, "_info"}, chk_info_o, make_rec(eh, es));
        end
        check({tag, "_total"}, PW'(total_cnt_o), PW'(et));
    endtask

    task automatic step(input logic [NH-1:0] v, input logic r,
                        input logic hl, input logic rs);
        logic [NH-1:0] acc;
        @(negedge clk);
        for (int h = 0; h < NH; h++) begin
            drv_rec[h] = make_rec(h, pushcnt[h]);
            commit_info_i[h*PW +: PW] = drv_rec[h];
        end
        commit_valid_i = v;
        chk_ready_i = r;
        halt_i = hl;
        resume_i = rs;
        #1;
        acc = v & commit_ready_o;
        @(posedge clk);
        #1;
        for (int h = 0; h < NH; h++) begin
            if (acc[h]) pushcnt[h]++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        commit_valid_i = '0;
        chk_ready_i = 1'b0;
        halt_i = 1'b0;
        resume_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_valid", PW'(chk_valid_o), PW'(0));
        check("rst_hart", PW'(chk_hart_o), PW'(0));
        check("rst_info", chk_info_o, PW'(0));
        check("rst_seq", PW'(chk_seq_o), PW'(0));
        check("rst_halted", PW'(halted_o), PW'(0));
        check("rst_total", PW'(total_cnt_o), PW'(0));
        check("rst_ready", PW'(commit_ready_o), PW'(4'hF));
        @(negedge clk);
        rst_n = 1'b1;
        for (int h = 0; h < NH; h++) pushcnt[h] = 0;
    endtask

    task automatic model_reset();
        for (int h = 0; h < NH; h++) begin
            mq[h].delete();
            m_seqc[h] = '0;
        end
        m_valid = 1'b0;
        m_hart = 0;
        m_info = '0;
        m_seq = '0;
        m_ptr = 0;
        m_halted = 1'b0;
        m_total = '0;
    endtask

    // One clock of the checker-facing behaviour, from pre-edge state.
    task automatic model_update(input logic [NH-1:0] v, input logic r,
                                input logic hl, input logic rs);
        int  sizes [NH];
        int  g;
        bit  free;
        for (int h = 0; h < NH; h++) sizes[h] = mq[h].size();
        if (m_valid && r) m_total = m_total + 1;
        free = !m_valid || r;
        g = -1;
        if (!m_halted && free) begin
            for (int k = 0; k < NH; k++) begin
                int c;
                c = (m_ptr + k) % NH;
                if (g < 0 && sizes[c] > 0) g = c;
            end
        end
        if (g >= 0) begin
            m_valid = 1'b1;
            m_hart = g;
            m_info = mq[g].pop_front();
            m_seq = m_seqc[g];
            m_seqc[g] = m_seqc[g] + 1;
            m_ptr = (g + 1) % NH;
        end else if (free) begin
            m_valid = 1'b0;
        end
        for (int h = 0; h < NH; h++) begin
            if (v[h] && sizes[h] < DEP) mq[h].push_back(drv_rec[h]);
        end
        if (hl) m_halted = 1'b1;
        else if (rs) m_halted = 1'b0;
    endtask

    task automatic model_compare();
        logic [NH-1:0] exp_rdy;
        for (int h = 0; h < NH; h++) exp_rdy[h] = (mq[h].size() < DEP);
        check("rnd_valid", PW'(chk_valid_o), PW'(m_valid));
        if (m_valid) begin
            check("rnd_hart", PW'(chk_hart_o), PW'(m_hart));
            check("rnd_seq", PW'(chk_seq_o), PW'(m_seq));
            check("rnd_info", chk_info_o, m_info);
        end
        check("rnd_halted", PW'(halted_o), PW'(m_halted));
        check("rnd_total", PW'(total_cnt_o), PW'(m_total));
        check("rnd_ready", PW'(commit_ready_o), PW'(exp_rdy));
    endtask

    initial begin
        logic [NH-1:0] rv;
        logic          rr;
        logic          rh;
        logic          rs;
        int            dens;

        for (int h = 0; h < NH; h++) pushcnt[h] = 0;

        // Single hart latency, then four-way fairness from a fresh reset.
        vecs[0]  = mk(1, 4'b0100, 1, 0, 0, 0, 0);
        vecs[1]  = mk(0, 4'b0000, 1, 1, 2, 0, 0);
        vecs[2]  = mk(0, 4'b0000, 1, 0, 0, 0, 1);
        vecs[3]  = mk(1, 4'b1111, 1, 0, 0, 0, 0);
        vecs[4]  = mk(0, 4'b1111, 1, 1, 0, 0, 0);
        vecs[5]  = mk(0, 4'b1111, 1, 1, 1, 0, 1);
        vecs[6]  = mk(0, 4'b1111, 1, 1, 2, 0, 2);
        vecs[7]  = mk(0, 4'b1111, 1, 1, 3, 0, 3);
        vecs[8]  = mk(0, 4'b1111, 1, 1, 0, 1, 4);
        vecs[9]  = mk(0, 4'b1111, 1, 1, 1, 1, 5);
        vecs[10] = mk(0, 4'b0000, 1, 1, 2, 1, 6);
        vecs[11] = mk(0, 4'b0000, 1, 1, 3, 1, 7);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].rst) do_reset();
            step(vecs[i].v, vecs[i].r, 1'b0, 1'b0);
            expect_out($sformatf("vec%0d", i), vecs[i].e_val,
                       vecs[i].e_hart, vecs[i].e_seq, vecs[i].e_tot);
            check($sformatf("vec%0d_ready", i), PW'(commit_ready_o), PW'(4'hF));
            check($sformatf("vec%0d_halted", i), PW'(halted_o), PW'(0));
        end

        // Backpressure until hart 1 is full, then drain in order.
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            step(4'b0010, 1'b0, 1'b0, 1'b0);
            expect_out("bp", (k > 1), 1, 0, 0);
            check("bp_ready1", PW'(commit_ready_o[1]), PW'(k < 9));
        end
        for (int j = 1; j <= 8; j++) begin
            step((j == 1) ? 4'b0010 : 4'b0000, 1'b1, 1'b0, 1'b0);
            expect_out("bp_drain", 1'b1, 1, j, j);
        end
        step(4'b0000, 1'b1, 1'b0, 1'b0);
        expect_out("bp_end", 1'b0, 0, 0, 9);

        // Halt with a pending record, fill while halted, resume.
        do_reset();
        step(4'b0001, 1'b0, 1'b0, 1'b0);
        expect_out("h_push", 1'b0, 0, 0, 0);
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        expect_out("h_load", 1'b1, 0, 0, 0);
        step(4'b0001, 1'b0, 1'b1, 1'b0);
        expect_out("h_pend", 1'b1, 0, 0, 0);
        check("h_halted", PW'(halted_o), PW'(1));
        step(4'b0001, 1'b1, 1'b0, 1'b0);
        expect_out("h_acc", 1'b0, 0, 0, 1);
        check("h_halted2", PW'(halted_o), PW'(1));
        for (int k = 1; k <= 7; k++) begin
            step(4'b0001, 1'b1, 1'b0, 1'b0);
            expect_out("h_fill", 1'b0, 0, 0, 1);
            check("h_fill_halted", PW'(halted_o), PW'(1));
            check("h_fill_ready0", PW'(commit_ready_o[0]), PW'(k < 6));
        end
        step(4'b0000, 1'b1, 1'b0, 1'b1);
        expect_out("h_resume", 1'b0, 0, 0, 1);
        check("h_resumed", PW'(halted_o), PW'(0));
        for (int j = 1; j <= 8; j++) begin
            step(4'b0000, 1'b1, 1'b0, 1'b0);
            expect_out("h_drain", 1'b1, 0, j, j);
        end

        // Halt and resume together: halt wins, no grants.
        step(4'b1000, 1'b1, 1'b1, 1'b1);
        expect_out("col", 1'b0, 0, 0, 9);
        check("col_halted", PW'(halted_o), PW'(1));
        for (int k = 0; k < 2; k++) begin
            step(4'b0000, 1'b1, 1'b0, 1'b0);
            expect_out("col_hold", 1'b0, 0, 0, 9);
            check("col_hold_halted", PW'(halted_o), PW'(1));
        end
        step(4'b0000, 1'b1, 1'b0, 1'b1);
        check("col_resumed", PW'(halted_o), PW'(0));
        step(4'b0000, 1'b1, 1'b0, 1'b0);
        expect_out("col_grant", 1'b1, 3, 0, 9);

        // Asynchronous reset with records buffered and one pending.
        step(4'b0111, 1'b0, 1'b0, 1'b0);
        step(4'b0111, 1'b0, 1'b0, 1'b0);
        expect_out("ar_pend", 1'b1, 3, 0, 9);
        do_reset();
        step(4'b0010, 1'b1, 1'b0, 1'b0);
        expect_out("ar_push", 1'b0, 0, 0, 0);
        step(4'b0000, 1'b1, 1'b0, 1'b0);
        expect_out("ar_first", 1'b1, 1, 0, 0);

        // Random traffic against the reference model.
        do_reset();
        model_reset();
        dens = 5;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (cyc % 250 == 0) dens = $urandom_range(1, 9);
            for (int h = 0; h < NH; h++) rv[h] = ($urandom_range(0, 9) < dens);
            rr = ($urandom_range(0, 99) < 70);
            rh = ($urandom_range(0, 99) < 2);
            rs = ($urandom_range(0, 99) < 12);
            step(rv, rr, rh, rs);
            model_update(rv, rr, rh, rs);
            model_compare();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cosim_commit_sequencer.md
Name: cosim_commit_sequencer

Overview:
- Collects per-hart commit records from the cores' retire trace ports under MEEP co-simulation.
- Buffers each hart's records in its own FIFO and serialises them, round-robin across harts, onto a single registered valid/ready channel.
- That channel feeds the checker that performs the Spike step/commit comparison, one record at a time.
- Order within each hart is preserved. The checker can halt issue on a mismatch and later resume it.

Parameters:
- NUM_HARTS, 4, number of commit sources (≥2).
- FIFO_DEPTH, 8, entries per hart FIFO (power of two, ≥2).
- PAYLOAD_W, 168, commit record width: pc[63:0], ins[95:64], data[159:96], dst[164:160], reg_wr_valid[165], xcpt[166], rsvd[167].
- HART_W, $clog2(NUM_HARTS), hart index width.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- commit_valid_i  in  NUM_HARTS  per-hart record valid.
- commit_ready_o  out  NUM_HARTS  per-hart FIFO not full.
- commit_info_i  in  NUM_HARTS*PAYLOAD_W  per-hart record; hart h occupies slice [h*PAYLOAD_W +: PAYLOAD_W].
- chk_valid_o  out  1  output record valid.
- chk_ready_i  in  1  checker accepts the record.
- chk_hart_o  out  HART_W  source hart of the output record.
- chk_info_o  out  PAYLOAD_W  output record.
- chk_seq_o  out  32  per-hart sequence number of the output record.
- halt_i  in  1  checker mismatch; stop issuing.
- resume_i  in  1  leave halt.
- halted_o  out  1  block is in HALT.
- total_cnt_o  out  32  records accepted by the checker since reset.

Behaviour:
- Reset (async, rst_n=0):
  - chk_valid_o=0, chk_hart_o=0, chk_info_o=0, chk_seq_o=0, halted_o=0, total_cnt_o=0.
  - All FIFOs empty; commit_ready_o all 1.
  - Round-robin pointer = 0; per-hart sequence counters = 0; state = RUN.
  - Reset asserted mid-operation discards all buffered and pending records.
- Enqueue:
  - Hart h pushes on a rising edge with commit_valid_i[h] && commit_ready_o[h].
  - commit_ready_o[h] = !full[h], combinational from FIFO count only; no dependency on the pop in the same cycle.
  - A full FIFO therefore refuses input even in a cycle where it pops.
- Output register:
  - It is "free" when chk_valid_o=0, or when chk_valid_o && chk_ready_i (back-to-back refill, no bubble).
  - In RUN with the register free and at least one FIFO non-empty, the arbiter grants one hart. That hart's FIFO head is popped and loaded into chk_info_o/chk_hart_o/chk_seq_o on the same edge, and chk_valid_o=1.
  - Free but nothing to load: chk_valid_o goes 0.
- Latency: record valid at hart in cycle t, with FIFO empty and output free → chk_valid_o=1 in cycle t+2.
- Arbitration:
  - Grant = first non-empty hart at or after the pointer, in increasing index with wrap.
  - On a grant to hart g, pointer ← (g+1) mod NUM_HARTS. Pointer unchanged when there is no grant.
- Sequence numbers:
  - chk_seq_o = hart g's counter value before the grant; that counter then increments.
  - 32-bit counters wrap 0xFFFFFFFF→0.
- Stability: while chk_valid_o && !chk_ready_i, all chk_* outputs hold.
- total_cnt_o: increments on each chk_valid_o && chk_ready_i; wraps.
- State machine:
  - RUN→HALT when halt_i=1 at an edge; halted_o=1 from the next cycle.
  - In HALT there are no grants. A record already in the output register stays valid and may still be accepted. After acceptance chk_valid_o goes 0.
  - FIFOs keep accepting input until full.
  - HALT→RUN when resume_i=1 and halt_i=0 at an edge. If halt_i and resume_i are both 1, halt wins and the state is HALT.
  - In the RUN→HALT cycle itself a grant still occurs if the register is free; halt blocks grants from the next edge.
- Simultaneous push and pop on the same FIFO: both occur; count unchanged.

Test Plan:
- Single hart: hart 2 sends pc=0x8000_0000 at cycle 0, chk_ready_i=1 → chk_valid_o at cycle 2, chk_hart_o=2, chk_seq_o=0, total_cnt_o=1 after acceptance.
- Fairness: all 4 harts hold valid continuously, chk_ready_i=1 → grant order 0,1,2,3,0,… with one record per cycle; each hart's seq increments 0,1,2…
- Backpressure and full: chk_ready_i=0, hart 1 streams 10 records → commit_ready_o[1]=0 after 9 acceptances (8 FIFO + 1 output register). chk_* stable throughout. Releasing ready drains in order with seq 0..8.
- Halt: halt_i pulsed while hart 0's record is pending → that record is still accepted, then chk_valid_o=0 and halted_o=1. The hart 0 FIFO fills to 8 while halted. resume_i → draining restarts from the hart 0 FIFO head.
- Halt/resume collision: halt_i=resume_i=1 in the same cycle → halted_o=1, no grants.
- Async reset mid-stream with 3 records buffered → outputs zero immediately, all commit_ready_o=1, seq restarts at 0.
